lvds_tx_serializer: RTL and testbench

Transmit-side 7:1 LVDS serializer: accepts 14-bit parallel words (two 7-bit symbols) and emits them two bits per clock as rising/falling-edge bit pairs for the DDR output buffers. After reset it sends a programmable 7-bit training pattern long enough for the far-end deserializer to lock and assert its alignment flag. It then streams user data, or an idle word when none is offered. It sits between the pixel/packet formatter and the DDR output I/O cells, mirroring the receive-side deserializer bit order exactly.

---
 rtl/lvds_tx_pkg.sv | 7 +
 rtl/lvds_tx_serializer.sv | 61 ++++++
 tb/tb_lvds_tx_serializer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/lvds_tx_pkg.sv
// lvds_tx_pkg: width constants and FSM encoding shared by the LVDS serializer and deserializer
package lvds_tx_pkg;
  localparam int WORD_W = 14;
  localparam int SYM_W = 7;
  localparam int PHASE_LAST = 6;
  typedef enum logic {ST_TRAIN, ST_DATA} state_t;
endpackage

// File: rtl/lvds_tx_serializer.sv
// lvds_tx_serializer: 7:1 DDR serializer sending a training preamble, then user data or idle words
module lvds_tx_serializer
  import lvds_tx_pkg::*;
#(
  parameter int TRAIN_WORDS = 64,
  parameter logic [WORD_W-1:0] IDLE_WORD = '0
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [SYM_W-1:0]  training_pattern,
  input  logic              train_req,
  input  logic [WORD_W-1:0] Data_in,
  input  logic              Data_valid,
  output logic              Data_ready,
  output logic              output_rising,
  output logic              output_falling,
  output logic              training
);
  localparam int TCNT_W = $clog2(TRAIN_WORDS + 1);
  state_t state;
  logic [2:0] phase;
  logic [WORD_W-1:0] sr;
  logic [TCNT_W-1:0] tcnt;
  logic req_pend;
  logic load, trained, req, go_data;
  // a train_req pulse seen mid-word is held until the next word boundary
  assign req = train_req | req_pend;
  assign load = phase == 3'(PHASE_LAST);
  assign trained = tcnt >= TCNT_W'(TRAIN_WORDS);
  assign go_data = !req && (state == ST_DATA || trained);
  assign Data_ready = load && go_data;
  assign output_rising = sr[WORD_W-1];
  assign output_falling = sr[WORD_W-2];
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= ST_TRAIN;
      phase <= 3'(PHASE_LAST);
      sr <= '0;
      tcnt <= '0;
      req_pend <= 1'b0;
      training <= 1'b0;
    end else if (load) begin
      phase <= '0;
      req_pend <= 1'b0;
      if (go_data) begin
        sr <= Data_valid ? Data_in : IDLE_WORD;
        state <= ST_DATA;
        training <= 1'b0;
      end else begin
        sr <= {training_pattern, training_pattern};
        state <= ST_TRAIN;
        training <= 1'b1;
        tcnt <= req ? TCNT_W'(1) : trained ? tcnt : tcnt + 1'b1;
      end
    end else begin
      sr <= sr << 2;
      phase <= phase + 1'b1;
      req_pend <= req_pend | train_req;
    end
  end
endmodule

// File: tb/tb_lvds_tx_serializer.sv
// tb_lvds_tx_serializer: scoreboard bench with serial-pair queue and loopback deserializer model
module tb_lvds_tx_serializer;
  localparam int N = 4;
  logic CLK = 0;
  logic RESET = 1;
  logic [6:0] training_pattern = 7'b1100011;
  logic train_req = 0;
  logic [13:0] Data_in = '0;
  logic Data_valid = 0;
  logic Data_ready, output_rising, output_falling, training;
  logic [13:0] tw;
  int checks = 0;
  int errors = 0;
  logic [2:0] exp_q[$];
  logic [13:0] data_q[$];
  logic mon_en = 0;
  logic rx_al = 0;
  int rx_cnt = 0;
  logic [13:0] rx_sr = '0;
  assign tw = {training_pattern, training_pattern};
  lvds_tx_serializer #(.TRAIN_WORDS(N), .IDLE_WORD(14'h0000)) dut (
    .CLK(CLK), .RESET(RESET), .training_pattern(training_pattern), .train_req(train_req),
    .Data_in(Data_in), .Data_valid(Data_valid), .Data_ready(Data_ready),
    .output_rising(output_rising), .output_falling(output_falling), .training(training)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic push_word(input logic [13:0] w, input logic t);
    for (int p = 0; p < 7; p++) exp_q.push_back({w[13-2*p], w[12-2*p], t});
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  // one full word period starting at its load cycle; optional train_req pulse at phase req_at
  task automatic word(input logic [13:0] din, input logic v, input logic exp_rdy,
                      input logic [13:0] exp_w, input logic exp_trn, input int req_at);
    Data_in = din;
    Data_valid = v;
    train_req = 0;
    #1;
    chk("ready_load", {13'b0, Data_ready}, {13'b0, exp_rdy});
    push_word(exp_w, exp_trn);
    if (!exp_trn) data_q.push_back(exp_w);
    for (int i = 0; i < 6; i++) begin
      tick();
      train_req = (i == req_at);
      #1;
      chk("ready_mid", {13'b0, Data_ready}, 14'h0);
    end
    tick();
    train_req = 0;
  endtask
  initial begin
    logic [2:0] e;
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL serial_underrun at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("serial", {11'b0, output_rising, output_falling, training}, {11'b0, e});
        end
      end
      if (RESET) begin
        rx_al = 0;
        rx_cnt = 0;
        rx_sr = '0;
      end else if (mon_en) begin
        rx_sr = {rx_sr[11:0], output_rising, output_falling};
        if (!rx_al) begin
          if (rx_sr == tw) begin
            rx_al = 1;
            rx_cnt = 0;
          end
        end else if (++rx_cnt == 7) begin
          rx_cnt = 0;
          if (rx_sr != tw) begin
            if (data_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL loopback_extra: got %h expected none", rx_sr);
            end else chk("loopback", rx_sr, data_q.pop_front());
          end
        end
      end
    end
  end
  initial begin
    repeat (3) @(posedge CLK);
    #1;
    RESET = 0;
    exp_q.delete();
    exp_q.push_back(3'b000);
    mon_en = 1;
    for (int k = 0; k < N; k++) word(14'h0, 0, 0, tw, 1, -1);
    chk("rx_aligned", {13'b0, rx_al}, 14'h1);
    word(14'h2AAA, 1, 1, 14'h2AAA, 0, -1);
    word(14'h1555, 1, 1, 14'h1555, 0, -1);
    word(14'h3FFF, 0, 1, 14'h0000, 0, -1);
    word(14'h0F0F, 1, 1, 14'h0F0F, 0, 3);
    for (int k = 0; k < N; k++) word(14'h1234, 1, 0, tw, 1, -1);
    word(14'h0CC3, 1, 1, 14'h0CC3, 0, -1);
    Data_in = 14'h1A5A;
    Data_valid = 1;
    #1;
    chk("ready_pre_reset", {13'b0, Data_ready}, 14'h1);
    push_word(14'h1A5A, 0);
    repeat (5) tick();
    RESET = 1;
    data_q.delete();
    tick();
    RESET = 0;
    Data_valid = 0;
    exp_q.delete();
    exp_q.push_back(3'b000);
    chk("reset_out", {11'b0, output_rising, output_falling, training}, 14'h0);
    chk("reset_ready", {13'b0, Data_ready}, 14'h0);
    for (int k = 0; k < N; k++) word(14'h0, 0, 0, tw, 1, -1);
    chk("rx_realigned", {13'b0, rx_al}, 14'h1);
    word(14'h2AAA, 1, 1, 14'h2AAA, 0, -1);
    word(14'h0, 0, 1, 14'h0000, 0, -1);
    @(negedge CLK);
    #1;
    chk("data_q_empty", 14'(data_q.size()), 14'h0);
    chk("exp_q_empty", 14'(exp_q.size()), 14'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
